// File: rtl/display_pkg.sv
// Shared types and constants for the display scheduler.
package display_pkg;

    typedef logic [31:0] disp_word_t;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } sched_state_t;

    localparam disp_word_t DISP_BLANK_VALUE = 32'h0000_0000;

endpackage : display_pkg

// File: rtl/dwell_timer.sv
// Counts one-hertz ticks and pulses expire_out on the tick that completes a
// dwell period. clear_in wins over hold_in, hold_in wins over a tick.
// expire_out is a same-cycle decode so the scheduler can advance on the
// expiring tick itself.
module dwell_timer #(
    parameter int DWELL_S = 3
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic tick_in,
    input  logic clear_in,
    input  logic hold_in,
    output logic expire_out
);

    localparam int CNT_W = $clog2(DWELL_S + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_S - 1);

    logic [CNT_W-1:0] dwell_cnt_q;
    logic [CNT_W-1:0] dwell_cnt_d;
    logic             expire_s;

    // Next dwell count and expiry decode.
    always_comb begin
        dwell_cnt_d = dwell_cnt_q;
        expire_s    = 1'b0;
        if (clear_in) begin
            dwell_cnt_d = {CNT_W{1'b0}};
        end else if (hold_in) begin
            dwell_cnt_d = dwell_cnt_q;
        end else if (tick_in) begin
            if (dwell_cnt_q == CNT_LAST) begin
                dwell_cnt_d = {CNT_W{1'b0}};
                expire_s    = 1'b1;
            end else begin
                dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
            end
        end else begin
            dwell_cnt_d = dwell_cnt_q;
        end
    end

    // Dwell count register with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dwell_cnt_q <= {CNT_W{1'b0}};
        end else begin
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    assign expire_out = expire_s;

endmodule : dwell_timer

// File: rtl/display_scheduler.sv
// Shares one 32-bit seven-segment value among N_SOURCES measurement sources.
// Selection is by next/prev pulses or auto-rotation every DWELL_S one-hertz
// ticks; each switch is followed by BLANK_CYCLES cycles of blank display.
// Optional freeze/snapshot feature: define DISPLAY_SCHEDULER_FREEZE_EN.
module display_scheduler
    import display_pkg::*;
#(
    parameter int N_SOURCES    = 4,
    parameter int DWELL_S      = 3,
    parameter int BLANK_CYCLES = 2,
    localparam int IDX_W       = (N_SOURCES < 2) ? 1 : $clog2(N_SOURCES)
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [32*N_SOURCES-1:0]   sources_in,
    input  logic                      one_hz_in,
    input  logic                      next_in,
    input  logic                      prev_in,
    input  logic                      auto_en_in,
    input  logic                      freeze_in,
    output logic [31:0]               display_out,
    output logic [IDX_W-1:0]          index_out,
    output logic                      blank_out,
    output logic                      frozen_out
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SOURCES - 1);
    localparam int               BLK_W    = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES);
    localparam logic [BLK_W-1:0] BLK_INIT = BLK_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    sched_state_t     state_q,     state_d;
    logic [IDX_W-1:0] index_q,     index_d;
    logic [BLK_W-1:0] blank_cnt_q, blank_cnt_d;
    disp_word_t       display_q,   display_d;
    logic             blank_q,     blank_d;

    logic       in_show_s;
    logic       gate_s;
    logic       adv_next_s;
    logic       adv_prev_s;
    logic       manual_s;
    logic       expire_s;
    logic       adv_any_s;
    logic       dwell_clear_s;
    logic       show_frozen_s;
    disp_word_t frozen_val_s;

    // Select source idx out of the packed source bus.
    function automatic disp_word_t pick_src(input logic [32*N_SOURCES-1:0] srcs,
                                            input logic [IDX_W-1:0]       idx);
        disp_word_t r;
        r = DISP_BLANK_VALUE;
        for (int k = 0; k < N_SOURCES; k++) begin
            r = (idx == IDX_W'(k)) ? srcs[32*k +: 32] : r;
        end
        return r;
    endfunction

`ifdef DISPLAY_SCHEDULER_FREEZE_EN
    logic       freeze_prev_q;
    logic       frozen_q, frozen_d;
    disp_word_t snap_q,   snap_d;
    logic       rise_s;
    logic       fall_s;

    // Freeze edge detection and snapshot capture; rises during BLANK are dropped.
    always_comb begin
        rise_s   = freeze_in & ~freeze_prev_q & (state_q == SHOW) & ~frozen_q;
        fall_s   = ~freeze_in & freeze_prev_q;
        frozen_d = frozen_q;
        snap_d   = snap_q;
        if (rise_s) begin
            frozen_d = 1'b1;
            snap_d   = pick_src(sources_in, index_q);
        end else if (fall_s) begin
            frozen_d = 1'b0;
        end else begin
            frozen_d = frozen_q;
        end
        gate_s        = frozen_q | rise_s;
        show_frozen_s = frozen_d;
        frozen_val_s  = snap_d;
    end

    // Freeze state registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            freeze_prev_q <= 1'b0;
            frozen_q      <= 1'b0;
            snap_q        <= DISP_BLANK_VALUE;
        end else begin
            freeze_prev_q <= freeze_in;
            frozen_q      <= frozen_d;
            snap_q        <= snap_d;
        end
    end

    assign frozen_out = frozen_q;
`else
    logic unused_freeze_s;

    assign unused_freeze_s = freeze_in;
    assign gate_s          = 1'b0;
    assign show_frozen_s   = 1'b0;
    assign frozen_val_s    = DISP_BLANK_VALUE;
    assign frozen_out      = 1'b0;
`endif

    // Advance decode: next beats prev beats auto expiry; only in SHOW, not frozen.
    always_comb begin
        in_show_s     = (state_q == SHOW);
        adv_next_s    = in_show_s & ~gate_s & next_in;
        adv_prev_s    = in_show_s & ~gate_s & ~next_in & prev_in;
        manual_s      = adv_next_s | adv_prev_s;
        dwell_clear_s = ~in_show_s | ~auto_en_in | manual_s;
        adv_any_s     = manual_s | expire_s;
    end

    dwell_timer #(
        .DWELL_S (DWELL_S)
    ) u_dwell_timer (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .tick_in    (one_hz_in),
        .clear_in   (dwell_clear_s),
        .hold_in    (gate_s),
        .expire_out (expire_s)
    );

    // Next-state, index and registered-output computation.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        blank_cnt_d = blank_cnt_q;
        display_d   = DISP_BLANK_VALUE;
        blank_d     = 1'b0;
        case (state_q)
            SHOW: begin
                if (adv_any_s) begin
                    if (adv_prev_s) begin
                        index_d = (index_q == {IDX_W{1'b0}}) ? IDX_LAST : index_q - IDX_W'(1);
                    end else begin
                        index_d = (index_q == IDX_LAST) ? {IDX_W{1'b0}} : index_q + IDX_W'(1);
                    end
                    if (BLANK_CYCLES > 0) begin
                        state_d     = BLANK;
                        blank_cnt_d = BLK_INIT;
                    end else begin
                        state_d     = SHOW;
                        blank_cnt_d = {BLK_W{1'b0}};
                    end
                end else begin
                    state_d = SHOW;
                end
            end
            BLANK: begin
                if (blank_cnt_q == {BLK_W{1'b0}}) begin
                    state_d = SHOW;
                end else begin
                    blank_cnt_d = blank_cnt_q - BLK_W'(1);
                end
            end
            default: begin
                state_d     = SHOW;
                blank_cnt_d = {BLK_W{1'b0}};
            end
        endcase

        if (state_d == BLANK) begin
            display_d = DISP_BLANK_VALUE;
            blank_d   = 1'b1;
        end else if (show_frozen_s) begin
            display_d = frozen_val_s;
            blank_d   = 1'b0;
        end else begin
            display_d = pick_src(sources_in, index_d);
            blank_d   = 1'b0;
        end
    end

    // Scheduler state and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= SHOW;
            index_q     <= {IDX_W{1'b0}};
            blank_cnt_q <= {BLK_W{1'b0}};
            display_q   <= DISP_BLANK_VALUE;
            blank_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            blank_cnt_q <= blank_cnt_d;
            display_q   <= display_d;
            blank_q     <= blank_d;
        end
    end

    assign display_out = display_q;
    assign index_out   = index_q;
    assign blank_out   = blank_q;

endmodule : display_scheduler

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler (N_SOURCES=4, DWELL_S=3, BLANK_CYCLES=2).
// Stimulus pushes cycle-stamped expectations; a negedge monitor checks them.
module tb_display_scheduler;

    logic         clk = 1'b0;
    logic         rst_in;
    logic [127:0] sources;
    logic         one_hz, next_p, prev_p, auto_en, freeze;
    logic [31:0]  display_out;
    logic [1:0]   index_out;
    logic         blank_out, frozen_out;
    logic [31:0]  src_v [4];

    typedef struct {
        int          cyc;
        string       nm;
        logic [1:0]  idx;
        logic [31:0] disp;
        logic        blank;
        logic        frozen;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    assign sources = {src_v[3], src_v[2], src_v[1], src_v[0]};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    display_scheduler #(
        .N_SOURCES    (4),
        .DWELL_S      (3),
        .BLANK_CYCLES (2)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst_in),
        .sources_in  (sources),
        .one_hz_in   (one_hz),
        .next_in     (next_p),
        .prev_in     (prev_p),
        .auto_en_in  (auto_en),
        .freeze_in   (freeze),
        .display_out (display_out),
        .index_out   (index_out),
        .blank_out   (blank_out),
        .frozen_out  (frozen_out)
    );

    // Monitor: pop every expectation due this cycle and compare.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            n_cmp = n_cmp + 1;
            if (mon_e.cyc != cyc) begin
                n_bad = n_bad + 1;
                $display("FAIL %s: expectation for cyc %0d checked late at cyc %0d", mon_e.nm, mon_e.cyc, cyc);
            end else if (index_out !== mon_e.idx || display_out !== mon_e.disp ||
                         blank_out !== mon_e.blank || frozen_out !== mon_e.frozen) begin
                n_bad = n_bad + 1;
                $display("FAIL %s @cyc %0d: got idx=%0d disp=%h blank=%0b frozen=%0b, want idx=%0d disp=%h blank=%0b frozen=%0b",
                         mon_e.nm, cyc, index_out, display_out, blank_out, frozen_out,
                         mon_e.idx, mon_e.disp, mon_e.blank, mon_e.frozen);
            end
        end
    end

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input int at, input string nm, input logic [1:0] ix,
                        input logic [31:0] d, input logic b, input logic f);
        exp_t e;
        int   pos;
        e.cyc = at; e.nm = nm; e.idx = ix; e.disp = d; e.blank = b; e.frozen = f;
        pos = sb_q.size();
        while (pos > 0 && sb_q[pos-1].cyc > at) pos = pos - 1;
        sb_q.insert(pos, e);
    endtask

    // One-cycle next/prev pulse: two blank cycles, then the new source.
    task automatic step(input logic n, input logic p, input logic [1:0] ni,
                        input logic [31:0] nd, input string nm);
        int c;
        c = cyc;
        next_p = n;
        prev_p = p;
        push(c + 1, {nm, "_blank1"}, ni, 32'h0, 1'b1, 1'b0);
        push(c + 2, {nm, "_blank2"}, ni, 32'h0, 1'b1, 1'b0);
        push(c + 3, {nm, "_show"},   ni, nd,    1'b0, 1'b0);
        ticks(1);
        next_p = 1'b0;
        prev_p = 1'b0;
        ticks(9);
    endtask

    // One one-hertz tick; optionally a second tick while blanking.
    task automatic hz(input logic adv, input logic [1:0] ni, input logic [31:0] nd,
                      input logic extra, input string nm);
        int c;
        c = cyc;
        one_hz = 1'b1;
        if (adv) begin
            push(c + 1, {nm, "_blank1"}, ni, 32'h0, 1'b1, 1'b0);
            push(c + 2, {nm, "_blank2"}, ni, 32'h0, 1'b1, 1'b0);
            push(c + 3, {nm, "_show"},   ni, nd,    1'b0, 1'b0);
        end else begin
            push(c + 1, {nm, "_hold"}, ni, nd, 1'b0, 1'b0);
        end
        ticks(1);
        one_hz = extra;
        ticks(1);
        one_hz = 1'b0;
        ticks(18);
    endtask

    initial begin
        int c;
        int guard;
        src_v[0] = 32'hA0; src_v[1] = 32'hA1; src_v[2] = 32'hA2; src_v[3] = 32'hA3;
        rst_in = 1'b1; one_hz = 1'b0; next_p = 1'b0; prev_p = 1'b0;
        auto_en = 1'b0; freeze = 1'b0;
        ticks(3);
        push(cyc, "reset", 2'd0, 32'h0, 1'b0, 1'b0);
        rst_in = 1'b0;
        for (int i = 1; i <= 5; i++) push(cyc + i, "idle", 2'd0, 32'hA0, 1'b0, 1'b0);
        ticks(6);

        // Manual navigation with wrap in both directions.
        step(1'b1, 1'b0, 2'd1, 32'hA1, "next0to1");
        step(1'b0, 1'b1, 2'd0, 32'hA0, "prev1to0");
        step(1'b0, 1'b1, 2'd3, 32'hA3, "prev0to3");
        step(1'b1, 1'b0, 2'd0, 32'hA0, "next3to0");
        step(1'b1, 1'b0, 2'd1, 32'hA1, "rot1");
        step(1'b1, 1'b0, 2'd2, 32'hA2, "rot2");
        step(1'b1, 1'b0, 2'd3, 32'hA3, "rot3");
        step(1'b1, 1'b0, 2'd0, 32'hA0, "rot0");

        // Auto rotation every third tick; a tick during blanking is not counted.
        auto_en = 1'b1;
        ticks(2);
        hz(1'b0, 2'd0, 32'hA0, 1'b0, "hz_a1");
        hz(1'b0, 2'd0, 32'hA0, 1'b0, "hz_a2");
        hz(1'b1, 2'd1, 32'hA1, 1'b1, "hz_adv1");
        hz(1'b0, 2'd1, 32'hA1, 1'b0, "hz_b1");
        hz(1'b0, 2'd1, 32'hA1, 1'b0, "hz_b2");
        hz(1'b1, 2'd2, 32'hA2, 1'b0, "hz_adv2");
        hz(1'b0, 2'd2, 32'hA2, 1'b0, "hz_c1");
        hz(1'b0, 2'd2, 32'hA2, 1'b0, "hz_c2");
        hz(1'b1, 2'd3, 32'hA3, 1'b0, "hz_adv3");
        hz(1'b0, 2'd3, 32'hA3, 1'b0, "hz_d1");
        hz(1'b0, 2'd3, 32'hA3, 1'b0, "hz_d2");
        hz(1'b1, 2'd0, 32'hA0, 1'b0, "hz_adv0");
        // Two ticks of progress, then auto_en low clears the dwell count.
        hz(1'b0, 2'd0, 32'hA0, 1'b0, "hz_e1");
        hz(1'b0, 2'd0, 32'hA0, 1'b0, "hz_e2");
        auto_en = 1'b0;
        ticks(5);
        auto_en = 1'b1;
        ticks(1);
        hz(1'b0, 2'd0, 32'hA0, 1'b0, "hz_clr1");
        hz(1'b0, 2'd0, 32'hA0, 1'b0, "hz_clr2");
        hz(1'b1, 2'd1, 32'hA1, 1'b0, "hz_clr_adv");
        auto_en = 1'b0;
        ticks(2);

        // next+prev together at index 2, then next during BLANK is dropped.
        step(1'b1, 1'b0, 2'd2, 32'hA2, "next1to2");
        c = cyc;
        next_p = 1'b1;
        prev_p = 1'b1;
        push(c + 1, "both_blank1", 2'd3, 32'h0, 1'b1, 1'b0);
        push(c + 2, "both_blank2", 2'd3, 32'h0, 1'b1, 1'b0);
        push(c + 3, "both_show", 2'd3, 32'hA3, 1'b0, 1'b0);
        push(c + 5, "blank_next_ignored", 2'd3, 32'hA3, 1'b0, 1'b0);
        ticks(1);
        prev_p = 1'b0;
        ticks(1);
        next_p = 1'b0;
        ticks(8);

        // Reset asserted in the middle of blanking.
        c = cyc;
        prev_p = 1'b1;
        push(c + 1, "pre_rst_blank", 2'd2, 32'h0, 1'b1, 1'b0);
        ticks(1);
        prev_p = 1'b0;
        rst_in = 1'b1;
        push(c + 2, "rst_midblank", 2'd0, 32'h0, 1'b0, 1'b0);
        ticks(1);
        rst_in = 1'b0;
        push(c + 3, "after_rst", 2'd0, 32'hA0, 1'b0, 1'b0);
        ticks(5);

`ifdef DISPLAY_SCHEDULER_FREEZE_EN
        step(1'b1, 1'b0, 2'd1, 32'hA1, "frz_pre");
        c = cyc;
        freeze = 1'b1;
        push(c + 1, "frz_on", 2'd1, 32'hA1, 1'b0, 1'b1);
        ticks(1);
        src_v[1] = 32'hBEEF;
        next_p = 1'b1;
        for (int i = 2; i <= 5; i++) push(c + i, "frz_hold", 2'd1, 32'hA1, 1'b0, 1'b1);
        ticks(1);
        next_p = 1'b0;
        ticks(5);
        c = cyc;
        freeze = 1'b0;
        push(c + 1, "frz_off", 2'd1, 32'hBEEF, 1'b0, 1'b0);
        ticks(3);
`else
        freeze = 1'b1;
        step(1'b1, 1'b0, 2'd1, 32'hA1, "nofrz_next");
        freeze = 1'b0;
`endif

        guard = 0;
        while (sb_q.size() > 0 && guard < 50) begin
            ticks(1);
            guard = guard + 1;
        end
        if (sb_q.size() > 0) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_display_scheduler
